// File: rtl/iq_packet_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : iq_packet_streamer
//  Description : Captures strobed I/Q samples into a two-bank ping-pong
//                buffer and streams each full bank as a framed packet
//                (sync, sequence, flags, payload, XOR checksum) over a
//                strobe/ack byte interface to a UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_packet_streamer #(
  parameter int          SAMPLE_W        = 12,
  parameter int          SAMPLES_PER_PKT = 64,
  parameter logic [15:0] SYNC_WORD       = 16'hA55A
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_sample_stb,
  input  logic [SAMPLE_W-1:0] i_sample_i,
  input  logic [SAMPLE_W-1:0] i_sample_q,
  output logic                o_tx_stb,
  output logic [7:0]          o_tx_data,
  input  logic                i_tx_ack,
  output logic [15:0]         o_drop_count,
  output logic                o_busy
);

  localparam int               BPS       = (2 * SAMPLE_W + 7) / 8;
  localparam int               WORD_W    = 8 * BPS;
  localparam int               PTR_W     = $clog2(SAMPLES_PER_PKT);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SAMPLES_PER_PKT - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(BPS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC_HI = 3'd1,
    ST_SYNC_LO = 3'd2,
    ST_SEQ     = 3'd3,
    ST_FLAGS   = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_CSUM    = 3'd6
  } state_t;

  // Both banks live in one array, addressed as {bank, sample index}
  logic [WORD_W-1:0] mem [0:2*SAMPLES_PER_PKT-1];

  state_t            state, state_next;
  logic [1:0]        full, full_eff, full_next;
  logic              wr_bank, wr_bank_next, tgt_bank;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_next;
  logic              rd_bank, rd_bank_next;
  logic [PTR_W-1:0]  sidx, sidx_next;
  logic [1:0]        bidx, bidx_next;
  logic [7:0]        seq, csum, csum_next, byte_next;
  logic              flag, ovf;
  logic              accept, start, rel_bank, write_ok, drop;
  logic [WORD_W-1:0] word_in, word_rd;

  assign o_tx_stb = (state != ST_IDLE);
  assign o_busy   = (state != ST_IDLE);
  assign accept   = o_tx_stb & i_tx_ack;
  assign rel_bank = (state == ST_CSUM) && accept;

  // Sample word {I, Q} zero-extended to a whole number of bytes
  always_comb begin
    word_in                   = '0;
    word_in[2*SAMPLE_W-1:0]   = {i_sample_i, i_sample_q};
  end

  // Bank occupancy seen by capture: a bank released this cycle is already free
  always_comb begin
    full_eff = full;
    if (rel_bank) full_eff[rd_bank] = 1'b0;
  end

  // A full write bank means the sample goes to the other bank if that is free
  assign tgt_bank = full_eff[wr_bank] ? ~wr_bank : wr_bank;
  assign write_ok = i_enable && i_sample_stb && !full_eff[tgt_bank];
  assign drop     = i_enable && i_sample_stb &&  full_eff[tgt_bank];

  // Write pointer, bank swap and bank-full bookkeeping
  always_comb begin
    full_next    = full_eff;
    wr_bank_next = wr_bank;
    wr_ptr_next  = wr_ptr;
    if (write_ok) begin
      wr_bank_next = tgt_bank;
      if (wr_ptr == LAST_PTR) begin
        full_next[tgt_bank] = 1'b1;
        wr_ptr_next         = '0;
        if (!full_eff[~tgt_bank]) wr_bank_next = ~tgt_bank;
      end else begin
        wr_ptr_next = wr_ptr + PTR_W'(1);
      end
    end else if (full_eff[wr_bank] && !full_eff[~wr_bank]) begin
      wr_bank_next = ~wr_bank;
    end
    if (!i_enable) wr_ptr_next = '0;
  end

  // Transmit FSM next-state and read position
  always_comb begin
    state_next   = state;
    rd_bank_next = rd_bank;
    sidx_next    = sidx;
    bidx_next    = bidx;
    start        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full[~wr_bank]) begin
          state_next   = ST_SYNC_HI;
          rd_bank_next = ~wr_bank;
          start        = 1'b1;
        end
      end
      ST_SYNC_HI: if (accept) state_next = ST_SYNC_LO;
      ST_SYNC_LO: if (accept) state_next = ST_SEQ;
      ST_SEQ:     if (accept) state_next = ST_FLAGS;
      ST_FLAGS: begin
        if (accept) begin
          state_next = ST_PAYLOAD;
          sidx_next  = '0;
          bidx_next  = '0;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          if (bidx == LAST_BYTE) begin
            bidx_next = '0;
            if (sidx == LAST_PTR) state_next = ST_CSUM;
            else                  sidx_next  = sidx + PTR_W'(1);
          end else begin
            bidx_next = bidx + 2'd1;
          end
        end
      end
      ST_CSUM:    if (accept) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Running checksum over SEQ, FLAGS and payload bytes as they are accepted
  always_comb begin
    csum_next = csum;
    if (start) begin
      csum_next = 8'h00;
    end else if (accept && (state == ST_SEQ || state == ST_FLAGS ||
                            state == ST_PAYLOAD)) begin
      csum_next = csum ^ o_tx_data;
    end
  end

  assign word_rd = mem[{rd_bank_next, sidx_next}];

  // Byte to present in the next cycle, selected by the next FSM position
  always_comb begin
    byte_next = 8'h00;
    case (state_next)
      ST_SYNC_HI: byte_next = SYNC_WORD[15:8];
      ST_SYNC_LO: byte_next = SYNC_WORD[7:0];
      ST_SEQ:     byte_next = seq;
      ST_FLAGS:   byte_next = {7'b0, flag};
      ST_PAYLOAD: begin
        for (int b = 0; b < BPS; b++) begin
          if (bidx_next == b[1:0]) byte_next = word_rd[8*(BPS-1-b) +: 8];
        end
      end
      ST_CSUM:    byte_next = csum_next;
      default:    byte_next = 8'h00;
    endcase
  end

  // Sample storage; contents need no reset since bank state gates every read
  always_ff @(posedge i_clk) begin
    if (write_ok) mem[{tgt_bank, wr_ptr}] <= word_in;
  end

  // State registers, counters and flags
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      full         <= 2'b00;
      wr_bank      <= 1'b0;
      wr_ptr       <= '0;
      rd_bank      <= 1'b0;
      sidx         <= '0;
      bidx         <= '0;
      seq          <= 8'h00;
      csum         <= 8'h00;
      flag         <= 1'b0;
      ovf          <= 1'b0;
      o_tx_data    <= 8'h00;
      o_drop_count <= 16'h0000;
    end else begin
      state     <= state_next;
      full      <= full_next;
      wr_bank   <= wr_bank_next;
      wr_ptr    <= wr_ptr_next;
      rd_bank   <= rd_bank_next;
      sidx      <= sidx_next;
      bidx      <= bidx_next;
      csum      <= csum_next;
      o_tx_data <= byte_next;
      if (rel_bank) seq <= seq + 8'd1;
      // Overflow is latched into the packet at its start; a drop in that
      // same cycle belongs to the following packet
      if (start) begin
        flag <= ovf;
        ovf  <= drop;
      end else if (drop) begin
        ovf  <= 1'b1;
      end
      if (drop && o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iq_packet_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iq_packet_streamer
//  Description : Randomized self-checking bench for iq_packet_streamer with a
//                queue-based packet reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_packet_streamer;

  localparam int SW  = 12;
  localparam int N   = 4;
  localparam int BPS = 3;

  logic        clk = 1'b0;
  logic        rst_n, enable, sample_stb, tx_ack;
  logic [SW-1:0] sample_i, sample_q;
  logic        tx_stb, busy;
  logic [7:0]  tx_data;
  logic [15:0] drop_count;

  iq_packet_streamer #(
    .SAMPLE_W        (SW),
    .SAMPLES_PER_PKT (N),
    .SYNC_WORD       (16'hA55A)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_sample_stb (sample_stb),
    .i_sample_i   (sample_i),
    .i_sample_q   (sample_q),
    .o_tx_stb     (tx_stb),
    .o_tx_data    (tx_data),
    .i_tx_ack     (tx_ack),
    .o_drop_count (drop_count),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [23:0] pend_w[$];   // words of full banks, in-flight packet first
  logic [23:0] partial[$];  // words of the bank being filled
  logic [7:0]  exp_q[$];    // remaining bytes of the packet in flight
  logic [7:0]  m_seq;
  bit          m_ovf;
  int          m_drops;
  bit          in_pkt;
  int          wait_cnt;
  logic        last_stb, last_busy;
  logic [7:0]  last_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_packet();
    logic [7:0]  fl, cs, b;
    logic [23:0] w;
    fl = {7'b0, m_ovf};
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(m_seq);
    exp_q.push_back(fl);
    cs = m_seq ^ fl;
    for (int s = 0; s < N; s++) begin
      w = pend_w[s];
      for (int k = BPS - 1; k >= 0; k--) begin
        b = 8'((w >> (8 * k)) & 24'hFF);
        exp_q.push_back(b);
        cs ^= b;
      end
    end
    exp_q.push_back(cs);
  endtask

  // One clock: record what was driven, cross the edge, update model, check
  task automatic cycle();
    logic        p_rst, p_en, p_sstb, p_ack, pv_stb, pv_busy;
    logic [7:0]  pv_data;
    logic [23:0] p_w;
    p_rst = rst_n; p_en = enable; p_sstb = sample_stb; p_ack = tx_ack;
    p_w = {sample_i, sample_q};
    pv_stb = last_stb; pv_busy = last_busy; pv_data = last_data;
    @(negedge clk);
    if (!p_rst) begin
      pend_w.delete(); partial.delete(); exp_q.delete();
      m_seq = 8'h00; m_ovf = 0; m_drops = 0; in_pkt = 0; wait_cnt = 0;
      chk("rst_stb",  tx_stb, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_count, 0);
    end else begin
      if (pv_stb && p_ack) begin
        chk("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("byte", pv_data, exp_q.pop_front());
          if (exp_q.size() == 0) begin
            repeat (N) void'(pend_w.pop_front());
            m_seq++;
            in_pkt = 0;
            chk("busy_end", busy, 0);
          end
        end
      end else if (pv_stb) begin
        chk("hold_stb",  tx_stb, 1);
        chk("hold_data", tx_data, pv_data);
      end
      if (busy && !pv_busy) begin
        chk("start_pending", pend_w.size() >= N, 1);
        chk("start_latency", wait_cnt <= 2, 1);
        if (pend_w.size() >= N) begin
          build_packet();
          m_ovf  = 0;
          in_pkt = 1;
        end
        wait_cnt = 0;
      end
      if (!p_en) begin
        partial.delete();
      end else if (p_sstb) begin
        if (pend_w.size() >= 2 * N) begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end else begin
          partial.push_back(p_w);
          if (partial.size() == N) begin
            foreach (partial[i]) pend_w.push_back(partial[i]);
            partial.delete();
          end
        end
      end
      if (pend_w.size() >= N && !in_pkt) wait_cnt++;
      chk("drop_count", drop_count, m_drops);
    end
    last_stb = tx_stb; last_busy = busy; last_data = tx_data;
  endtask

  task automatic strobe(input logic [SW-1:0] si, input logic [SW-1:0] sq);
    sample_stb = 1; sample_i = si; sample_q = sq;
    cycle();
    sample_stb = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    tx_ack = 1; sample_stb = 0;
    while ((pend_w.size() != 0 || busy) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", n < budget, 1);
  endtask

  initial begin
    int d0, n;
    rst_n = 0; enable = 0; sample_stb = 0; tx_ack = 0;
    sample_i = '0; sample_q = '0;
    last_stb = 0; last_busy = 0; last_data = 0;
    m_seq = 0; m_ovf = 0; m_drops = 0; in_pkt = 0; wait_cnt = 0;
    repeat (3) cycle();
    rst_n = 1; enable = 1;
    cycle();

    // Directed packet: constant sample, checksum cancels to zero
    tx_ack = 1;
    repeat (N) strobe(12'hABC, 12'h123);
    drain(100);

    // Long stall mid-payload
    repeat (N) strobe(SW'($urandom), SW'($urandom));
    repeat (8) cycle();
    tx_ack = 0;
    repeat (20) cycle();
    drain(100);

    // Slow continuous stream, immediate acks
    tx_ack = 1;
    for (int s = 0; s < 4 * N; s++) begin
      strobe(SW'($urandom), SW'($urandom));
      repeat (59) cycle();
    end
    drain(100);

    // Overflow: both banks fill while the transmitter is stalled
    d0 = m_drops;
    tx_ack = 0;
    for (int s = 0; s < 3 * N; s++) begin
      strobe(SW'($urandom), SW'($urandom));
      cycle();
    end
    chk("ovf_drops", drop_count, d0 + N);
    drain(200);
    repeat (N) strobe(SW'($urandom), SW'($urandom));
    drain(100);

    // Enable dropped after a partial bank
    strobe(12'h111, 12'h222);
    strobe(12'h333, 12'h444);
    enable = 0;
    strobe(12'h555, 12'h666);
    cycle();
    enable = 1;
    repeat (N) strobe(SW'($urandom), SW'($urandom));
    drain(100);

    // Random traffic with random acks and enable gaps
    for (int c = 0; c < 3000; c++) begin
      enable     = ($urandom_range(0, 49) != 0);
      sample_stb = ($urandom_range(0, 3) == 0);
      sample_i   = SW'($urandom);
      sample_q   = SW'($urandom);
      tx_ack     = ($urandom_range(0, 1) == 1);
      cycle();
    end
    enable = 1; sample_stb = 0;
    drain(400);

    // Reset in the middle of a payload
    tx_ack = 0;
    repeat (N) strobe(SW'($urandom), SW'($urandom));
    n = 0;
    while (!busy && n < 20) begin cycle(); n++; end
    chk("busy_wait", busy, 1);
    tx_ack = 1;
    repeat (7) cycle();
    tx_ack = 0;
    rst_n = 0;
    cycle();
    rst_n = 1;
    cycle();
    tx_ack = 1;
    repeat (N) strobe(SW'($urandom), SW'($urandom));
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
